find_wall_intersection_grid: RTL and testbench

- Parametrised successor to the horizontal-only wall intersection finder.
- Casts one ray against the maze grid in either horizontal-gridline or vertical-gridline mode, selected per calculation.
- Queries the maze map through a request/acknowledge read port and reports the first wall hit, or a miss.
- Sits between the per-column ray scheduler and the maze map RAM. Two instances, one per mode, or one time-shared instance, feed the distance/shading stage.

---
 rtl/ray_pkg.sv | 14 +
 rtl/ray_trig_lut.sv | 36 +++
 rtl/find_wall_intersection_grid.sv | 133 +++++++++++++
 tb/tb_find_wall_intersection_grid.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// ray_pkg: angle constants, FSM state type and mode encodings shared by the grid ray caster.
// Angle constants are given for a 12-bit reference circle; ang_scale rescales them to any ANGLE_W.
package ray_pkg;
   localparam int ANG_REF_W = 12;
   localparam int ANG_QUARTER = 1 << (ANG_REF_W - 2);
   localparam int ANG_HALF = 2 * ANG_QUARTER;
   localparam int ANG_3QUARTER = 3 * ANG_QUARTER;
   localparam logic MODE_HORIZ = 1'b0;
   localparam logic MODE_VERT = 1'b1;
   typedef enum logic [2:0] {S_IDLE, S_FIRST, S_OFFSET, S_BOUNDS, S_REQ, S_WAIT, S_STEP, S_DONE} state_t;
   function automatic int ang_scale(int a, int w);
      return (a << w) >> ANG_REF_W;
   endfunction
endpackage

// File: rtl/ray_trig_lut.sv
// ray_trig_lut: elaboration-time ROM of tan(alpha) in Q(FRAC_W), saturated near the asymptotes;
// cot(alpha) reuses the same table as tan(quarter - alpha).
module ray_trig_lut
   import ray_pkg::*;
#(
   parameter int ANGLE_W = 12,
   parameter int COORD_W = 12,
   parameter int FRAC_W = 8
) (
   input  logic [ANGLE_W-1:0]                alpha,
   output logic signed [COORD_W+FRAC_W-1:0]  tan_q,
   output logic signed [COORD_W+FRAC_W-1:0]  cot_q
);
   localparam int TW = COORD_W + FRAC_W;
   localparam int N = 1 << ANGLE_W;
   localparam real PI = 3.14159265358979323846;
   localparam real LIM = real'((1 << (TW - 1)) - 1);
   localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(ang_scale(ANG_QUARTER, ANGLE_W));
   function automatic logic signed [TW-1:0] tan_entry(int a);
      real s, c, v;
      s = $sin(2.0 * PI * a / N);
      c = $cos(2.0 * PI * a / N);
      v = (c < 1.0e-12 && c > -1.0e-12) ? ((s * c < 0.0) ? -LIM : LIM) : s / c * real'(1 << FRAC_W);
      v = v > LIM ? LIM : (v < -LIM ? -LIM : v);
      return TW'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
   endfunction
   logic signed [TW-1:0] tan_t [N];
   logic [ANGLE_W-1:0] cot_idx;
   for (genvar a = 0; a < N; a++) begin : g_rom
      localparam logic signed [TW-1:0] ENTRY = tan_entry(a);
      assign tan_t[a] = ENTRY;
   end
   assign cot_idx = QUARTER - alpha;
   assign tan_q = tan_t[alpha];
   assign cot_q = tan_t[cot_idx];
endmodule

// File: rtl/find_wall_intersection_grid.sv
// find_wall_intersection_grid: casts one ray along horizontal or vertical gridlines, reading the maze
// map cell by cell through a req/ack port until a wall, the map edge or the step limit is reached.
module find_wall_intersection_grid
   import ray_pkg::*;
#(
   parameter int COORD_W = 12,
   parameter int ANGLE_W = 12,
   parameter int CELL_LOG2 = 6,
   parameter int MAP_W = 8,
   parameter int MAP_H = 8,
   parameter int FRAC_W = 8,
   parameter int MAX_STEPS = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [COORD_W-1:0]                 playerX,
   input  logic [COORD_W-1:0]                 playerY,
   input  logic [ANGLE_W-1:0]                 alpha,
   input  logic                               mode,
   input  logic                               begin_calc,
   output logic                               map_req,
   output logic [$clog2(MAP_W*MAP_H)-1:0]     map_addr,
   input  logic                               map_ack,
   input  logic                               map_wall,
   output logic [COORD_W-1:0]                 wallX,
   output logic [COORD_W-1:0]                 wallY,
   output logic                               wall_found,
   output logic                               end_calc,
   output logic                               busy,
   output logic [$clog2(MAX_STEPS+1)-1:0]     step_count
);
   localparam int IW = COORD_W + 2;
   localparam int TW = COORD_W + FRAC_W;
   localparam int AW = $clog2(MAP_W * MAP_H);
   localparam int SW = $clog2(MAX_STEPS + 1);
   localparam logic signed [IW-1:0] CELL = IW'(1 << CELL_LOG2);
   localparam logic signed [IW-1:0] ONE = IW'(1);
   localparam logic signed [IW-1:0] X_END = IW'(MAP_W << CELL_LOG2);
   localparam logic signed [IW-1:0] Y_END = IW'(MAP_H << CELL_LOG2);
   localparam logic [ANGLE_W-1:0] QUARTER = ANGLE_W'(ang_scale(ANG_QUARTER, ANGLE_W));
   localparam logic [ANGLE_W-1:0] HALF = ANGLE_W'(ang_scale(ANG_HALF, ANGLE_W));
   localparam logic [ANGLE_W-1:0] Q3 = ANGLE_W'(ang_scale(ANG_3QUARTER, ANGLE_W));
   state_t state, state_n;
   logic [ANGLE_W-1:0] ang;
   logic mode_r, horiz, up, right, degen, out_of_map;
   logic signed [IW-1:0] px, py, cx, cy, xa, ya, al_x, al_y, first_x, first_y, mul_a, mres;
   logic signed [TW-1:0] tan_q, cot_q;
   logic signed [IW+TW-1:0] prod;
   ray_trig_lut #(.ANGLE_W(ANGLE_W), .COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_lut (
      .alpha(ang),
      .tan_q(tan_q),
      .cot_q(cot_q)
   );
   assign horiz = mode_r == MODE_HORIZ;
   assign up = ang != '0 && ang < HALF;
   assign right = ang < QUARTER || ang > Q3;
   assign degen = horiz ? (ang == '0 || ang == HALF) : (ang == QUARTER || ang == Q3);
   assign al_x = px & ~(CELL - ONE);
   assign al_y = py & ~(CELL - ONE);
   assign first_x = right ? al_x + CELL : al_x - ONE;
   assign first_y = up ? al_y - ONE : al_y + CELL;
   // One multiplier serves both the first intersection and the per-step offset
   assign mul_a = state == S_FIRST ? (horiz ? py - first_y : px - first_x)
                                   : (horiz ? (up ? CELL : -CELL) : (right ? -CELL : CELL));
   assign prod = mul_a * (horiz ? cot_q : tan_q);
   assign mres = IW'(prod >>> FRAC_W);
   assign out_of_map = cx[IW-1] || cy[IW-1] || cx >= X_END || cy >= Y_END;
   assign map_addr = AW'((cy >>> CELL_LOG2) * MAP_W + (cx >>> CELL_LOG2));
   assign wallX = cx[COORD_W-1:0];
   assign wallY = cy[COORD_W-1:0];
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      map_req = 1'b0;
      end_calc = 1'b0;
      busy = state != S_IDLE;
      case (state)
         S_IDLE:   state_n = begin_calc ? S_FIRST : S_IDLE;
         S_FIRST:  state_n = degen ? S_DONE : S_OFFSET;
         S_OFFSET: state_n = S_BOUNDS;
         S_BOUNDS: state_n = (out_of_map || step_count == SW'(MAX_STEPS)) ? S_DONE : S_REQ;
         S_REQ:    begin map_req = 1'b1; state_n = S_WAIT; end
         S_WAIT:   begin map_req = 1'b1; state_n = !map_ack ? S_WAIT : (map_wall ? S_DONE : S_STEP); end
         S_STEP:   state_n = S_BOUNDS;
         default:  begin end_calc = 1'b1; state_n = S_IDLE; end
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         ang <= '0;
         mode_r <= 1'b0;
         px <= '0;
         py <= '0;
         cx <= '0;
         cy <= '0;
         xa <= '0;
         ya <= '0;
         wall_found <= 1'b0;
         step_count <= '0;
      end else begin
         case (state)
            S_IDLE: if (begin_calc) begin
               ang <= alpha;
               mode_r <= mode;
               px <= IW'(playerX);
               py <= IW'(playerY);
               cx <= '0;
               cy <= '0;
               wall_found <= 1'b0;
               step_count <= '0;
            end
            S_FIRST: if (!degen) begin
               cx <= horiz ? px + mres : first_x;
               cy <= horiz ? first_y : py + mres;
            end
            S_OFFSET: begin
               xa <= horiz ? mres : (right ? CELL : -CELL);
               ya <= horiz ? (up ? -CELL : CELL) : mres;
            end
            S_WAIT: if (map_ack) begin
               step_count <= step_count + 1'b1;
               wall_found <= map_wall;
            end
            S_STEP: begin
               cx <= cx + xa;
               cy <= cy + ya;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_find_wall_intersection_grid.sv
// tb_find_wall_intersection_grid: table of hand-computed rays plus reset, busy and step-limit sequences.
`timescale 1ns/1ps
module tb_find_wall_intersection_grid;
   import ray_pkg::*;
   typedef struct {
      int px, py, alpha;
      logic mode;
      int lat, wall_at, found, x, y, steps, reads, faddr, cyc;
   } vec_t;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [11:0] px, py, alpha;
   logic mode, stray;
   logic bgn [2];
   logic req [2];
   logic [5:0] addr [2];
   logic ack [2];
   logic wall [2];
   logic [11:0] wx [2];
   logic [11:0] wy [2];
   logic found [2];
   logic endc [2];
   logic busy_o [2];
   logic [4:0] sc0;
   logic [1:0] sc1;
   logic wall_map [64];
   logic jitter [2];
   logic [5:0] req_addr [2];
   int reads [2];
   int nreq [2];
   int first_addr [2];
   int lat;
   int errors = 0, checks = 0;
   vec_t tv [12];
   vec_t vstep;
   always #5 clock = ~clock;
   find_wall_intersection_grid dut0 (
      .clock(clock), .reset(reset), .playerX(px), .playerY(py), .alpha(alpha), .mode(mode),
      .begin_calc(bgn[0]), .map_req(req[0]), .map_addr(addr[0]), .map_ack(ack[0]), .map_wall(wall[0]),
      .wallX(wx[0]), .wallY(wy[0]), .wall_found(found[0]), .end_calc(endc[0]), .busy(busy_o[0]),
      .step_count(sc0)
   );
   find_wall_intersection_grid #(.MAX_STEPS(2)) dut1 (
      .clock(clock), .reset(reset), .playerX(px), .playerY(py), .alpha(alpha), .mode(mode),
      .begin_calc(bgn[1]), .map_req(req[1]), .map_addr(addr[1]), .map_ack(ack[1]), .map_wall(wall[1]),
      .wallX(wx[1]), .wallY(wy[1]), .wall_found(found[1]), .end_calc(endc[1]), .busy(busy_o[1]),
      .step_count(sc1)
   );
   // Map RAM model: acknowledges each request lat cycles after the REQ cycle
   always @(negedge clock) begin
      for (int g = 0; g < 2; g++) begin
         if (req[g]) begin
            if (first_addr[g] < 0) first_addr[g] = int'(addr[g]);
            if (nreq[g] == 0) req_addr[g] = addr[g];
            else if (addr[g] != req_addr[g]) jitter[g] = 1'b1;
            ack[g] = (nreq[g] == lat + 1);
            wall[g] = wall_map[addr[g]];
            if (ack[g]) reads[g]++;
            nreq[g]++;
         end else begin
            ack[g] = stray;
            wall[g] = 1'b1;
            nreq[g] = 0;
         end
      end
   end
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic run(int d, vec_t v, string tag, bit glitch);
      int n;
      for (int i = 0; i < 64; i++) wall_map[i] = 1'b0;
      if (v.wall_at >= 0) wall_map[v.wall_at] = 1'b1;
      lat = v.lat;
      @(negedge clock);
      reads[d] = 0;
      first_addr[d] = -1;
      jitter[d] = 1'b0;
      px = 12'(v.px);
      py = 12'(v.py);
      alpha = 12'(v.alpha);
      mode = v.mode;
      bgn[d] = 1'b1;
      @(negedge clock);
      bgn[d] = 1'b0;
      n = 1;
      chk({tag, " busy"}, int'(busy_o[d]), 1);
      while (!endc[d] && n < 300) begin
         @(negedge clock);
         n++;
         if (glitch && n == 3) begin
            px = 12'd0;
            alpha = 12'd0;
            mode = MODE_VERT;
            bgn[d] = 1'b1;
         end else bgn[d] = 1'b0;
      end
      chk({tag, " end_calc"}, int'(endc[d]), 1);
      chk({tag, " wall_found"}, int'(found[d]), v.found);
      chk({tag, " step_count"}, d == 0 ? int'(sc0) : int'(sc1), v.steps);
      chk({tag, " reads"}, reads[d], v.reads);
      if (v.reads > 0) begin
         chk({tag, " first_addr"}, first_addr[d], v.faddr);
         chk({tag, " addr_stable"}, int'(jitter[d]), 0);
      end
      if (v.x >= 0) begin
         chk({tag, " wallX"}, int'(wx[d]), v.x);
         chk({tag, " wallY"}, int'(wy[d]), v.y);
      end
      if (v.cyc > 0) chk({tag, " latency"}, n, v.cyc);
      @(negedge clock);
      chk({tag, " end_pulse"}, int'(endc[d]), 0);
      chk({tag, " idle"}, int'(busy_o[d]), 0);
      chk({tag, " found_held"}, int'(found[d]), v.found);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int seen;
      bgn[0] = 1'b0;
      bgn[1] = 1'b0;
      stray = 1'b0;
      lat = 0;
      px = '0;
      py = '0;
      alpha = '0;
      mode = MODE_HORIZ;
      for (int g = 0; g < 2; g++) begin
         reads[g] = 0;
         nreq[g] = 0;
         first_addr[g] = -1;
         jitter[g] = 1'b0;
      end
      tv[0]  = '{96, 96, 1024, MODE_HORIZ, 0, 1, 1, 96, 63, 1, 1, 1, 6};
      tv[1]  = '{96, 96, 0, MODE_VERT, 3, 10, 1, 128, 96, 1, 1, 10, 9};
      tv[2]  = '{96, 96, 1024, MODE_HORIZ, 1, -1, 0, -1, 0, 1, 1, 1, 9};
      tv[3]  = '{96, 96, 0, MODE_HORIZ, 0, -1, 0, -1, 0, 0, 0, 0, 2};
      tv[4]  = '{96, 96, 3072, MODE_HORIZ, 2, 17, 1, 96, 128, 1, 1, 17, 0};
      tv[5]  = '{200, 96, 2048, MODE_VERT, 0, 9, 1, 127, 96, 2, 2, 10, 0};
      tv[6]  = '{96, 96, 512, MODE_HORIZ, 0, 2, 1, 129, 63, 1, 1, 2, 0};
      tv[7]  = '{96, 96, 512, MODE_VERT, 1, 3, 1, 192, 0, 2, 2, 10, 0};
      tv[8]  = '{96, 96, 341, MODE_HORIZ, 0, 2, 1, 153, 63, 1, 1, 2, 0};
      tv[9]  = '{96, 96, 341, MODE_VERT, 0, 10, 1, 128, 77, 1, 1, 10, 0};
      tv[10] = '{96, 96, 1024, MODE_VERT, 0, -1, 0, -1, 0, 0, 0, 0, 2};
      tv[11] = '{32, 480, 1024, MODE_HORIZ, 0, -1, 0, -1, 0, 7, 7, 48, 0};
      vstep  = '{32, 480, 1024, MODE_HORIZ, 0, -1, 0, -1, 0, 2, 2, 48, 12};
      repeat (2) @(negedge clock);
      chk("reset map_req", int'(req[0]), 0);
      chk("reset end_calc", int'(endc[0]), 0);
      chk("reset busy", int'(busy_o[0]), 0);
      chk("reset wall_found", int'(found[0]), 0);
      chk("reset step_count", int'(sc0), 0);
      chk("reset wallXY", int'({wx[0], wy[0]}), 0);
      chk("reset map_addr", int'(addr[0]), 0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) run(0, tv[i], $sformatf("vec%0d", i), 1'b0);
      run(1, vstep, "step_limit", 1'b0);
      run(0, tv[1], "ignored_begin", 1'b1);
      stray = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clock);
         seen += int'(busy_o[0]) + int'(endc[0]);
      end
      stray = 1'b0;
      chk("stray_ack idle", seen, 0);
      for (int i = 0; i < 64; i++) wall_map[i] = 1'b0;
      wall_map[1] = 1'b1;
      lat = 20;
      @(negedge clock);
      px = 12'd96;
      py = 12'd96;
      alpha = 12'd1024;
      mode = MODE_HORIZ;
      bgn[0] = 1'b1;
      @(negedge clock);
      bgn[0] = 1'b0;
      repeat (6) @(negedge clock);
      chk("mid_wait map_req", int'(req[0]), 1);
      #2 reset = 1'b1;
      #1;
      chk("reset map_req drop", int'(req[0]), 0);
      chk("reset busy drop", int'(busy_o[0]), 0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clock);
         seen += int'(endc[0]);
      end
      chk("reset no end_calc", seen, 0);
      run(0, tv[0], "after_reset", 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
